// File: rtl/mips_pkg.sv
// Shared MIPS encodings: control-unit ALU ops plus the HI/LO multiply/divide unit's
// operation codes, FSM states and a small magnitude helper.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Codes 6 and 7 are undefined and treated as no-ops by the mul/div unit.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } md_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mips_div_core.sv
// Unsigned restoring divider: one quotient bit per run cycle, paced by a down-counter
// whose terminal count flags the final iteration.
module mips_div_core #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        run,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);
    localparam int CW = $clog2(DIV_ITERS + 1);

    logic [31:0]   div_q;
    logic [CW-1:0] count;
    logic [32:0]   partial;
    logic [32:0]   trial;

    // Quotient register doubles as the dividend shift register.
    assign partial = {remainder, quotient[31]};
    assign trial   = partial - {1'b0, div_q};
    assign last    = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            remainder <= '0;
            quotient  <= '0;
            div_q     <= '0;
            count     <= '0;
        end else if (load) begin
            remainder <= '0;
            quotient  <= dividend;
            div_q     <= divisor;
            count     <= CW'(DIV_ITERS);
        end else if (run && count != '0) begin
            if (!trial[32]) begin
                remainder <= trial[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= partial[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, iterative DIV/DIVU with sign fix-up.
//   state   | meaning
//   IDLE    | accepting operations, busy=0
//   DIV_RUN | divider producing one quotient bit per cycle
//   DIV_FIX | sign correction, HI/LO written at end of this cycle
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_e   state;
    md_state_e   state_next;
    md_op_e      op_e;
    logic        accept;
    logic        is_div;
    logic        is_signed_div;
    logic        div_req;
    logic        div_load;
    logic        div_run;
    logic        div_last;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign op_e          = md_op_e'(op);
    assign accept        = start && (state == IDLE);
    assign is_div        = (op_e == MD_DIV) || (op_e == MD_DIVU);
    assign is_signed_div = (op_e == MD_DIV);
    // Divide by zero never enters the divider: HI/LO are simply left alone.
    assign div_req       = accept && is_div && (rt_val != '0);

    assign dividend_mag = is_signed_div ? abs32(rs_val) : rs_val;
    assign divisor_mag  = is_signed_div ? abs32(rt_val) : rt_val;

    assign mul_a   = (op_e == MD_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    assign mul_b   = (op_e == MD_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    assign product = mul_a * mul_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_req) state_next = DIV_RUN;
            DIV_RUN: if (div_last) state_next = DIV_FIX;
            DIV_FIX: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        div_load = 1'b0;
        div_run  = 1'b0;
        case (state)
            IDLE:    div_load = div_req;
            DIV_RUN: begin
                busy    = 1'b1;
                div_run = 1'b1;
            end
            DIV_FIX: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    mips_div_core #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .run       (div_run),
        .dividend  (dividend_mag),
        .divisor   (divisor_mag),
        .quotient  (quo_mag),
        .remainder (rem_mag),
        .last      (div_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (div_load) begin
            neg_quo <= is_signed_div && (rs_val[31] ^ rt_val[31]);
            neg_rem <= is_signed_div && rs_val[31];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == DIV_FIX) begin
                lo   <= neg_quo ? (~quo_mag + 32'd1) : quo_mag;
                hi   <= neg_rem ? (~rem_mag + 32'd1) : rem_mag;
                done <= 1'b1;
            end else if (accept) begin
                case (op_e)
                    MD_MULT, MD_MULTU: {hi, lo} <= product;
                    MD_MTHI:           hi <= rs_val;
                    MD_MTLO:           lo <= rs_val;
                    default:           ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: directed and random operations against an arithmetic HI/LO model.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    localparam int DIV_ITERS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mips_muldiv_unit #(.DIV_ITERS(DIV_ITERS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {hi,lo} of one operation.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = 64'(sa * sb); return p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
            3'd2: begin
                if (b == 0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {h, l};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_simple(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input string name);
        logic [63:0] exp;
        exp = model(o, a, b, hi_m, lo_m);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        step();
        start = 1'b0;
        total++; if (hi !== exp[63:32]) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, exp[63:32]); end
        total++; if (lo !== exp[31:0]) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, exp[31:0]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy: got %b want 0", name, busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done: got %b want 0", name, done); end
        hi_m = exp[63:32];
        lo_m = exp[31:0];
    endtask

    // poke >= 0 re-asserts start (as MTHI) at that cycle of the run; chain issues MULTU right after done.
    task automatic run_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int poke, input bit chain, input string name);
        logic [63:0] exp;
        logic [63:0] exp2;
        int busy_cnt;
        int cyc;
        bit hold_ok;
        exp = model(o, a, b, hi_m, lo_m);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        step();
        start = 1'b0;
        if (b == 0) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s div0 busy: got %b want 0", name, busy); end
            total++; if (hi !== hi_m) begin bad++; $display("FAIL %s div0 hi: got %h want %h", name, hi, hi_m); end
            total++; if (lo !== lo_m) begin bad++; $display("FAIL %s div0 lo: got %h want %h", name, lo, lo_m); end
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s div0 done: got %b want 0", name, done); end
            return;
        end
        busy_cnt = 0;
        cyc = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (hi !== hi_m || lo !== lo_m) hold_ok = 1'b0;
            if (cyc == poke) begin
                start = 1'b1; op = MD_MTHI; rs_val = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done timeout: got %b want 1", name, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy at done: got %b want 0", name, busy); end
        total++; if (busy_cnt != DIV_ITERS + 1) begin bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, DIV_ITERS + 1); end
        total++; if (!hold_ok) begin bad++; $display("FAIL %s hold: got changed hi/lo want held", name); end
        total++; if (hi !== exp[63:32]) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, exp[63:32]); end
        total++; if (lo !== exp[31:0]) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, exp[31:0]); end
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        if (chain) begin
            exp2 = model(MD_MULTU, 32'h0001_0003, 32'h0002_0005, hi_m, lo_m);
            start = 1'b1; op = MD_MULTU; rs_val = 32'h0001_0003; rt_val = 32'h0002_0005;
            step();
            start = 1'b0;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s chain done: got %b want 0", name, done); end
            total++; if ({hi, lo} !== exp2) begin bad++; $display("FAIL %s chain hilo: got %h want %h", name, {hi, lo}, exp2); end
            hi_m = exp2[63:32];
            lo_m = exp2[31:0];
        end else begin
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done width: got %b want 0", name, done); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = MD_MTHI; rs_val = 32'h5555_AAAA;
        step();
        step();
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset hi: got %h want 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset lo: got %h want 0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        reset = 1'b0; start = 1'b0;
        hi_m = '0; lo_m = '0;
    endtask

    task automatic test_mult();
        run_simple(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL mult_neg2x3 const: got %h want fffffffffffffffa", {hi, lo}); end
        run_simple(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_max const: got %h want fffffffe00000001", {hi, lo}); end
        for (int i = 0; i < 20; i++) begin
            run_simple((($urandom & 1) != 0) ? MD_MULT : MD_MULTU, $urandom, $urandom, "mult_rand");
        end
    endtask

    task automatic test_mthi_mtlo();
        for (int i = 0; i < 8; i++) begin
            run_simple((($urandom & 1) != 0) ? MD_MTHI : MD_MTLO, $urandom, $urandom, "mthi_mtlo_rand");
        end
    endtask

    task automatic test_undefined_op();
        run_simple(3'd6, $urandom, $urandom, "undef_op6");
        run_simple(3'd7, $urandom, $urandom, "undef_op7");
    endtask

    task automatic test_div();
        run_div(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_neg7_2");
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg7_2 const: got %h want fffffffffffffffd", {hi, lo}); end
        run_div(MD_DIVU, 32'd100, 32'd7, 10, 1'b0, "divu_100_7_restart");
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 const: got %h want 000000020000000e", {hi, lo}); end
        run_div(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div_overflow");
        total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_overflow const: got %h want 0000000080000000", {hi, lo}); end
        run_div(MD_DIV, 32'h1234_5678, 32'd0, -1, 1'b0, "div_by_zero");
        run_div(MD_DIVU, 32'hCAFE_F00D, 32'd0, -1, 1'b0, "divu_by_zero");
    endtask

    task automatic test_div_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (($urandom & 3) == 0) ? $urandom : ($urandom_range(1, 300) ^ ((($urandom & 1) != 0) ? 32'hFFFF_FFFF : 32'h0));
            if (b == 0) b = 32'd5;
            run_div((($urandom & 1) != 0) ? MD_DIV : MD_DIVU, a, b, -1, 1'b0, "div_rand");
        end
    endtask

    task automatic test_back_to_back();
        run_div(MD_DIV, 32'd1000, 32'hFFFF_FFFD, -1, 1'b1, "b2b_div_then_multu");
        run_div(MD_DIVU, $urandom, 32'd13, -1, 1'b1, "b2b_divu_then_multu");
    endtask

    task automatic test_reset_mid_div();
        bit stray;
        start = 1'b1; op = MD_DIV; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_mid hi: got %h want 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_mid lo: got %h want 0", lo); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_mid done: got %b want 0", done); end
        hi_m = '0; lo_m = '0;
        stray = 1'b0;
        for (int i = 0; i < DIV_ITERS + 8; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        total++; if (stray) begin bad++; $display("FAIL reset_mid aftermath: got done/busy activity want none"); end
        run_simple(MD_MTHI, 32'h0000_1234, 32'h0, "reset_mid_mthi");
        total++; if ({hi, lo} !== 64'h0000_1234_0000_0000) begin bad++; $display("FAIL reset_mid_mthi const: got %h want 0000123400000000", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mthi_mtlo();
        test_undefined_op();
        test_div();
        test_div_random();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 SHALL have parameter DIV_ITERS, default 32, meaning quotient bits produced by the iterative divider (one per cycle).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request, sampled only on a rising edge where busy=0.
REQ-005 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port rs_val  input  32  first operand (dividend, multiplicand, or MTHI/MTLO source).
REQ-007 SHALL have port rt_val  input  32  second operand (divisor, multiplier).
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO are updated by DIV/DIVU.
REQ-010 SHALL have port hi  output  32  HI register contents, for MFHI.
REQ-011 SHALL have port lo  output  32  LO register contents, for MFLO.

Function
REQ-012 SHALL implement FSM states IDLE, DIV_RUN and DIV_FIX.
REQ-013 SHALL, in IDLE, accept start with MULT/MULTU and write the 64-bit product to {hi,lo} at the next edge; busy stays 0 and done stays 0.
REQ-014 SHALL treat MULT operands as two's complement and MULTU operands as unsigned.
REQ-015 SHALL, for MTHI/MTLO accepted at edge N, write rs_val to hi or lo at edge N+1 and leave the other register unchanged.
REQ-016 SHALL, for DIV/DIVU accepted at edge N, latch operand magnitudes and signs, enter DIV_RUN and assert busy from edge N+1.
REQ-017 SHALL remain in DIV_RUN for exactly DIV_ITERS cycles, producing one quotient bit per cycle by restoring division.
REQ-018 SHALL spend one cycle in DIV_FIX applying the sign correction, then write lo=quotient and hi=remainder at edge N+DIV_ITERS+1.
REQ-019 SHALL, at edge N+DIV_ITERS+1, pulse done for one cycle, deassert busy and return to IDLE.
REQ-020 SHALL truncate the DIV quotient toward zero and give the remainder the sign of the dividend.
REQ-021 SHALL, for DIV with 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0.
REQ-022 SHALL, for divisor 0, complete in one cycle with no busy and no done, leaving hi and lo unchanged.
REQ-023 SHALL ignore start while busy=1; hi and lo hold their values throughout a division.
REQ-024 SHALL treat an undefined op value with start=1 as a no-op.
REQ-025 SHALL drive hi and lo directly from registers, with no combinational path from inputs.
REQ-026 SHALL allow a new operation to be accepted on the same edge at which done is deasserted, with busy=0.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, force state=IDLE, busy=0, done=0, hi=0 and lo=0.
REQ-028 SHALL abort any in-progress division on reset without producing a done pulse.
REQ-029 SHALL give reset priority over a simultaneous start.

Structure
REQ-030 SHALL define the op encoding enum and the FSM state enum in shared package mips_pkg, alongside the existing control-unit encodings.
REQ-031 SHALL place the unsigned iterative divider datapath (remainder, quotient and counter registers) in sub-module mips_div_core; sign handling and HI/LO stay in the top module.

Verification
REQ-032 SHALL cover MULT: rs=0xFFFFFFFE (-2), rt=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy never high.
REQ-033 SHALL cover MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL cover DIV: rs=-7, rt=2 -> busy for 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), single done pulse.
REQ-035 SHALL cover DIVU: 100/7 with start re-asserted mid-run -> extra start ignored; lo=14, hi=2 after 33 cycles.
REQ-036 SHALL cover DIV 0x80000000 / -1 -> lo=0x80000000, hi=0; divide by zero -> hi and lo unchanged, no busy.
REQ-037 SHALL cover reset at DIV_RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done; MTHI 0x1234 afterwards -> hi=0x1234, lo=0.
